dsp_read_channel_decerr: RTL



---
 rtl/dsp_read_channel_decerr.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_read_channel_decerr.sv
// Read-channel dispatcher for one AXI4 master port.
// Decodes ARADDR to a slave port (or to an internal DECERR responder),
// forwards AR combinationally, and keeps an in-order queue of outstanding
// reads so that R beats are returned to the master in AR issue order.
// Each slave also has an outstanding-transaction limit.
module dsp_read_channel_decerr #(
    parameter int SLV_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int OUTST_PER_SLV     = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int SLV_ID_MSB_IDX    = 30,
    parameter int SLV_ID_LSB_IDX    = 30
) (
    input  logic                                    ACLK_i,
    input  logic                                    ARESET_i,
    // Master AR
    input  logic [TRANS_MST_ID_W-1:0]               m_ARID_i,
    input  logic [ADDR_WIDTH-1:0]                   m_ARADDR_i,
    input  logic [TRANS_BURST_W-1:0]                m_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]             m_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]            m_ARSIZE_i,
    input  logic                                    m_ARVALID_i,
    output logic                                    m_ARREADY_o,
    // Master R
    output logic [TRANS_MST_ID_W-1:0]               m_RID_o,
    output logic [DATA_WIDTH-1:0]                   m_RDATA_o,
    output logic [1:0]                              m_RRESP_o,
    output logic                                    m_RLAST_o,
    output logic                                    m_RVALID_o,
    input  logic                                    m_RREADY_i,
    // Slave-arbitration AR
    output logic [TRANS_MST_ID_W*SLV_AMT-1:0]       sa_ARID_o,
    output logic [ADDR_WIDTH*SLV_AMT-1:0]           sa_ARADDR_o,
    output logic [TRANS_BURST_W*SLV_AMT-1:0]        sa_ARBURST_o,
    output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]     sa_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]    sa_ARSIZE_o,
    output logic [SLV_AMT-1:0]                      sa_ARVALID_o,
    input  logic [SLV_AMT-1:0]                      sa_ARREADY_i,
    output logic [SLV_AMT-1:0]                      sa_AR_outst_full_o,
    // Slave-arbitration R
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]       sa_RID_i,
    input  logic [DATA_WIDTH*SLV_AMT-1:0]           sa_RDATA_i,
    input  logic [2*SLV_AMT-1:0]                    sa_RRESP_i,
    input  logic [SLV_AMT-1:0]                      sa_RLAST_i,
    input  logic [SLV_AMT-1:0]                      sa_RVALID_i,
    output logic [SLV_AMT-1:0]                      sa_RREADY_o
);

    localparam int SEL_W   = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;
    localparam int TAG_W   = $clog2(SLV_AMT + 1);
    localparam int PTR_W   = $clog2(OUTSTANDING_AMT);
    localparam int QCNT_W  = PTR_W + 1;
    localparam int CNT_W   = $clog2(OUTST_PER_SLV + 1);
    localparam int ID_W    = TRANS_MST_ID_W;
    localparam int LEN_W   = TRANS_DATA_LEN_W;

    localparam logic [TAG_W-1:0]  DECERR_TAG = TAG_W'(SLV_AMT);
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    // Address decode
    logic [SEL_W-1:0]   w_sel;
    logic               w_decerr;
    logic [TAG_W-1:0]   w_push_tag;
    logic [CNT_W-1:0]   w_sel_cnt;
    logic               w_sel_arready;
    logic               w_ar_ok;
    logic               w_ar_hs;

    // Order queue
    logic [TAG_W-1:0]   r_q_tag [OUTSTANDING_AMT];
    logic [ID_W-1:0]    r_q_id  [OUTSTANDING_AMT];
    logic [LEN_W-1:0]   r_q_len [OUTSTANDING_AMT];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [QCNT_W-1:0]  r_q_count;
    logic               w_q_full;
    logic               w_q_empty;
    logic [TAG_W-1:0]   w_head_tag;
    logic [ID_W-1:0]    w_head_id;
    logic [LEN_W-1:0]   w_head_len;
    logic               w_head_decerr;

    // R path and per-slave accounting
    logic [LEN_W-1:0]   r_beat_cnt;
    logic               w_r_hs;
    logic               w_r_last_hs;
    logic [CNT_W-1:0]   r_cnt [SLV_AMT];
    logic [SLV_AMT-1:0] w_cnt_inc;
    logic [SLV_AMT-1:0] w_cnt_dec;

    // The AR payload goes to every slave port; only ARVALID is steered.
    assign sa_ARID_o    = {SLV_AMT{m_ARID_i}};
    assign sa_ARADDR_o  = {SLV_AMT{m_ARADDR_i}};
    assign sa_ARBURST_o = {SLV_AMT{m_ARBURST_i}};
    assign sa_ARLEN_o   = {SLV_AMT{m_ARLEN_i}};
    assign sa_ARSIZE_o  = {SLV_AMT{m_ARSIZE_i}};

    assign w_q_full      = (r_q_count == QCNT_W'(OUTSTANDING_AMT));
    assign w_q_empty     = (r_q_count == '0);
    assign w_head_tag    = r_q_tag[r_rd_ptr];
    assign w_head_id     = r_q_id[r_rd_ptr];
    assign w_head_len    = r_q_len[r_rd_ptr];
    assign w_head_decerr = (w_head_tag == DECERR_TAG);

    // Decode the slave-select field and gate AR on queue space and slave limit.
    always_comb begin
        w_sel         = m_ARADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
        w_decerr      = 1'b1;
        w_push_tag    = DECERR_TAG;
        w_sel_cnt     = '0;
        w_sel_arready = 1'b0;
        for (int k = 0; k < SLV_AMT; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_decerr      = 1'b0;
                w_push_tag    = TAG_W'(k);
                w_sel_cnt     = r_cnt[k];
                w_sel_arready = sa_ARREADY_i[k];
            end
        end
        // Reset masks the handshake so nothing is pushed while it is held.
        w_ar_ok = m_ARVALID_i & ~w_q_full & ~ARESET_i &
                  (w_decerr | (w_sel_cnt < CNT_W'(OUTST_PER_SLV)));
        for (int k = 0; k < SLV_AMT; k++) begin
            sa_ARVALID_o[k] = w_ar_ok & ~w_decerr & (w_sel == SEL_W'(k));
        end
        m_ARREADY_o = w_ar_ok & (w_decerr | w_sel_arready);
        w_ar_hs     = m_ARVALID_i & m_ARREADY_o;
    end

    // Steer R from the slave (or DECERR responder) at the head of the queue.
    always_comb begin
        m_RID_o     = '0;
        m_RDATA_o   = '0;
        m_RRESP_o   = '0;
        m_RLAST_o   = 1'b0;
        m_RVALID_o  = 1'b0;
        sa_RREADY_o = '0;
        if (!w_q_empty && !ARESET_i) begin
            if (w_head_decerr) begin
                m_RVALID_o = 1'b1;
                m_RID_o    = w_head_id;
                m_RRESP_o  = RESP_DECERR;
                m_RLAST_o  = (r_beat_cnt == w_head_len);
            end else begin
                for (int k = 0; k < SLV_AMT; k++) begin
                    if (w_head_tag == TAG_W'(k)) begin
                        m_RID_o        = sa_RID_i[k*ID_W +: ID_W];
                        m_RDATA_o      = sa_RDATA_i[k*DATA_WIDTH +: DATA_WIDTH];
                        m_RRESP_o      = sa_RRESP_i[k*2 +: 2];
                        m_RLAST_o      = sa_RLAST_i[k];
                        m_RVALID_o     = sa_RVALID_i[k];
                        sa_RREADY_o[k] = m_RREADY_i;
                    end
                end
            end
        end
        w_r_hs      = m_RVALID_o & m_RREADY_i;
        w_r_last_hs = w_r_hs & m_RLAST_o;
    end

    // Queue pointers and occupancy; a same-cycle push and pop leave occupancy unchanged.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_ar_hs) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_r_last_hs) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_ar_hs, w_r_last_hs})
                2'b10:   r_q_count <= r_q_count + QCNT_W'(1);
                2'b01:   r_q_count <= r_q_count - QCNT_W'(1);
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    // Queue storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge ACLK_i) begin
        if (w_ar_hs) begin
            r_q_tag[r_wr_ptr] <= w_push_tag;
            r_q_id[r_wr_ptr]  <= m_ARID_i;
            r_q_len[r_wr_ptr] <= m_ARLEN_i;
        end
    end

    // DECERR beat counter: advances per accepted beat, clears after the last one.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_beat_cnt <= '0;
        end else if (w_r_hs && w_head_decerr) begin
            if (m_RLAST_o) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
        end
    end

    // Per-slave increment on AR issue and decrement on the final R beat.
    always_comb begin
        w_cnt_inc = '0;
        w_cnt_dec = '0;
        for (int k = 0; k < SLV_AMT; k++) begin
            w_cnt_inc[k] = w_ar_hs & ~w_decerr & (w_sel == SEL_W'(k));
            w_cnt_dec[k] = w_r_last_hs & ~w_head_decerr & (w_head_tag == TAG_W'(k));
            sa_AR_outst_full_o[k] = ~ARESET_i & (r_cnt[k] == CNT_W'(OUTST_PER_SLV));
        end
    end

    // Per-slave outstanding counters; simultaneous inc and dec hold the value.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            for (int k = 0; k < SLV_AMT; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SLV_AMT; k++) begin
                case ({w_cnt_inc[k], w_cnt_dec[k]})
                    2'b10:   r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    2'b01:   r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                    default: r_cnt[k] <= r_cnt[k];
                endcase
            end
        end
    end

endmodule
